// File: rtl/multiple_byte_receiver.sv
// UART 8N1 receiver that reassembles NUM_BYTES MSB-first bytes into one word.
// Optional inter-byte idle timeout is enabled by defining MBR_TIMEOUT_EN.
module multiple_byte_receiver #(
    parameter int unsigned CLKS_PER_BIT    = 20,
    parameter int unsigned BITS_TO_RECEIVE = 24,
    parameter int unsigned TIMEOUT_BITS    = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       uart_input,
    output logic [BITS_TO_RECEIVE-1:0] data,
    output logic                       data_valid,
    output logic                       framing_error,
    output logic                       busy
);

    localparam int unsigned NUM_BYTES = (BITS_TO_RECEIVE + 7) / 8;
    localparam int unsigned WORD_W    = 8 * NUM_BYTES;
    localparam int unsigned CNT_W     = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W     = $clog2(NUM_BYTES + 1);

    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state;
    logic              sync_a, sync_b, sync_prev;
    logic              fall;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        rx_byte;
    logic [IDX_W-1:0]  byte_idx;
    logic [WORD_W-1:0] word;
    logic [WORD_W-1:0] word_shift;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_a    <= 1'b1;
            sync_b    <= 1'b1;
            sync_prev <= 1'b1;
        end else begin
            sync_a    <= uart_input;
            sync_b    <= sync_a;
            sync_prev <= sync_b;
        end
    end

    assign fall       = sync_prev & ~sync_b;
    assign word_shift = (word << 8) | WORD_W'(rx_byte);
    assign busy       = (state != IDLE) || (byte_idx != '0);

`ifdef MBR_TIMEOUT_EN
    localparam int unsigned TO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int unsigned TO_W      = $clog2(TO_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYCLES - 1);

    logic [TO_W-1:0] idle_cnt;
    logic            timed_out;

    // Runs only while a partial word waits in IDLE; any start edge restarts it.
    always_ff @(posedge clk) begin
        if (reset || state != IDLE || fall || byte_idx == '0) begin
            idle_cnt <= '0;
        end else if (idle_cnt != TO_LAST) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    assign timed_out = (idle_cnt == TO_LAST);
`else
    logic timed_out;
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            bit_idx       <= '0;
            rx_byte       <= '0;
            byte_idx      <= '0;
            word          <= '0;
            data          <= '0;
            data_valid    <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            data_valid    <= 1'b0;
            framing_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (fall) begin
                        state <= START;
                        cnt   <= HALF_BIT;
                    end else if (timed_out && byte_idx != '0) begin
                        byte_idx <= '0;
                        word     <= '0;
                    end
                end
                START: begin
                    if (cnt == '0) begin
                        if (!sync_b) begin
                            state   <= DATA;
                            cnt     <= FULL_BIT;
                            bit_idx <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == '0) begin
                        rx_byte <= {sync_b, rx_byte[7:1]};
                        cnt     <= FULL_BIT;
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                        if (sync_b) begin
                            if (byte_idx == LAST_IDX) begin
                                data       <= word_shift[BITS_TO_RECEIVE-1:0];
                                data_valid <= 1'b1;
                                byte_idx   <= '0;
                                word       <= '0;
                            end else begin
                                word     <= word_shift;
                                byte_idx <= byte_idx + 1'b1;
                            end
                        end else begin
                            framing_error <= 1'b1;
                            byte_idx      <= '0;
                            word          <= '0;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multiple_byte_receiver.sv
// Scoreboard bench: a byte-queue model predicts words, framing errors and pulse cycles.
module tb_multiple_byte_receiver;

    localparam int unsigned C         = 20;
    localparam int unsigned BITS      = 24;
    localparam int unsigned TO_BITS   = 16;
    localparam int unsigned NUM_BYTES = (BITS + 7) / 8;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            uart_input = 1'b1;
    logic [BITS-1:0] data;
    logic            data_valid;
    logic            framing_error;
    logic            busy;

    multiple_byte_receiver #(
        .CLKS_PER_BIT(C),
        .BITS_TO_RECEIVE(BITS),
        .TIMEOUT_BITS(TO_BITS)
    ) dut (
        .clk(clk),
        .reset(reset),
        .uart_input(uart_input),
        .data(data),
        .data_valid(data_valid),
        .framing_error(framing_error),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit              is_ferr;
        logic [BITS-1:0] word;
        int unsigned     cyc;
    } exp_t;

    exp_t       sbq[$];
    logic [7:0] partial[$];
    int         tests = 0;
    int         fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Line change at cycle n reaches the first sync flop at n+1, the edge is
    // detected two cycles later, and the stop sample lands C/2 + 9C after that.
    function automatic int unsigned pulse_cycle(input int unsigned n);
        return n + 3 + C / 2 + 9 * C;
    endfunction

    task automatic model_byte(input logic [7:0] b, input bit good_stop, input int unsigned n);
        exp_t e;
        logic [8*NUM_BYTES-1:0] w;
        if (good_stop) begin
            partial.push_back(b);
            if (partial.size() == NUM_BYTES) begin
                w = '0;
                foreach (partial[j]) w = (w << 8) | (8*NUM_BYTES)'(partial[j]);
                e.is_ferr = 1'b0;
                e.word    = w[BITS-1:0];
                e.cyc     = pulse_cycle(n);
                sbq.push_back(e);
                partial.delete();
            end
        end else begin
            e.is_ferr = 1'b1;
            e.word    = '0;
            e.cyc     = pulse_cycle(n);
            sbq.push_back(e);
            partial.delete();
        end
    endtask

    task automatic model_idle(input int unsigned idle_bits);
`ifdef MBR_TIMEOUT_EN
        if (idle_bits > TO_BITS) partial.delete();
`else
        if (idle_bits > TO_BITS) partial = partial;
`endif
    endtask

    task automatic drive_bit(input logic v);
        uart_input = v;
        repeat (C) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit good_stop, input int unsigned idle_bits);
        model_byte(b, good_stop, cyc);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(good_stop);
        for (int unsigned i = 0; i < idle_bits; i++) drive_bit(1'b1);
        model_idle(idle_bits);
    endtask

    task automatic send_word(input logic [BITS-1:0] w, input int unsigned idle_bits);
        logic [8*NUM_BYTES-1:0] pw;
        pw = (8*NUM_BYTES)'(w);
        for (int i = NUM_BYTES - 1; i >= 0; i--) send_byte(pw[8*i +: 8], 1'b1, idle_bits);
    endtask

    // Monitor: pops the scoreboard whenever the DUT pulses an output.
    logic [BITS-1:0] prev_data = '0;
    bit              rst_seen = 1'b1;
    always @(negedge clk) begin
        exp_t e;
        if (!reset && !rst_seen) begin
            if (data_valid && framing_error) check("pulse_exclusive", 32'd1, 32'd0);
            if (data_valid || framing_error) begin
                if (sbq.size() == 0) begin
                    check("unexpected_pulse", {30'd0, data_valid, framing_error}, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    check("pulse_kind", {31'd0, framing_error}, {31'd0, e.is_ferr});
                    check("pulse_cycle", cyc, e.cyc);
                    if (!e.is_ferr) check("word", 32'(data), 32'(e.word));
                end
            end
            if (!data_valid && data !== prev_data) check("data_hold", 32'(data), 32'(prev_data));
        end
        rst_seen  = reset;
        prev_data = data;
    end

    initial begin
        logic [7:0]  b;
        bit          good;
        int unsigned gap;

        repeat (3) @(posedge clk);
        #1;
        check("rst_data", 32'(data), 32'd0);
        check("rst_valid", {31'd0, data_valid}, 32'd0);
        check("rst_ferr", {31'd0, framing_error}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        repeat (2) drive_bit(1'b1);

        // Word reception with one idle bit between bytes.
        send_byte(8'h01, 1'b1, 1);
        send_byte(8'h23, 1'b1, 1);
        send_byte(8'h45, 1'b1, 1);
        check("busy_after_word", {31'd0, busy}, 32'd0);

        // Back-to-back words, no idle time.
        send_word(24'h000007, 0);
        send_word(24'hABCDEF, 0);
        repeat (2) drive_bit(1'b1);

        // Glitch rejection.
        uart_input = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        uart_input = 1'b1;
        repeat (3) drive_bit(1'b1);
        check("glitch_idle", {31'd0, busy}, 32'd0);
        send_word(24'h00002A, 1);

        // Framing error discards partial word.
        send_byte(8'h12, 1'b1, 0);
        send_byte(8'h34, 1'b0, 1);
        check("ferr_busy", {31'd0, busy}, 32'd0);
        send_word(24'h0A0B0C, 1);

        // Reset during DATA of the second byte.
        send_byte(8'h77, 1'b1, 1);
        check("partial_busy", {31'd0, busy}, 32'd1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        reset = 1'b1;
        uart_input = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_data", 32'(data), 32'd0);
        check("midrst_valid", {31'd0, data_valid}, 32'd0);
        check("midrst_ferr", {31'd0, framing_error}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        partial.delete();
        repeat (12) drive_bit(1'b1);
        send_word(24'h123456, 1);

        // Randomised words with occasional bad stop bits.
        for (int k = 0; k < 18; k++) begin
            b    = 8'($urandom);
            good = ($urandom_range(0, 9) != 0);
            gap  = $urandom_range(0, 2);
            if (!good && gap == 0) gap = 1;
            send_byte(b, good, gap);
        end
        repeat (2) drive_bit(1'b1);
        partial.delete();
        // Flush any random leftover partial word with a reset.
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) drive_bit(1'b1);

        // Inter-byte timeout behaviour.
        send_byte(8'hFF, 1'b1, 20);
        send_byte(8'h00, 1'b1, 1);
        send_byte(8'h01, 1'b1, 1);
        send_byte(8'h02, 1'b1, 1);
        repeat (4) drive_bit(1'b1);

        check("final_busy", {31'd0, busy}, {31'd0, partial.size() != 0});
        check("scoreboard_empty", sbq.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
